// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with single-cycle logic/arith/shift ops and
// iterative (one step per cycle) multiply and, optionally, divide.
// Optional feature macro: ALU_MULTICYCLE_DIV_EN enables DIVU/REMU through a
// restoring divider. Without it, DIVU/REMU decode as illegal opcodes.
// The FSM state is exported on dbg_state (IDLE=0, RUN=1, DONE=2).
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (state IDLE or DONE). opCode/a/b are captured on that edge only. busy=1
// exactly while an iterative op runs, and start is ignored then. done is a
// one-cycle pulse. out/v/err update only on the edge that raises done and
// hold until the next done.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opCode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             v,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
`ifdef ALU_MULTICYCLE_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;
`endif

    // Last iteration index: the step taken with cnt_q at this value is step WIDTH.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             v_q, v_d;
    logic             err_q, err_d;
    // acc: product high half / partial remainder. mq: multiplier / quotient.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // Selects the acc register (MULHU/REMU) rather than mq (MUL/DIVU) as result.
    logic             op_hi_q, op_hi_d;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic             op_div_q, op_div_d;
`endif

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_out;
    logic             sc_v;
    logic             sc_err;
    logic             op_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mq;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_mq;

    assign add_res = a + b;
    assign sub_res = a - b;
    assign shamt   = b[SHW-1:0];

    // Decode the incoming opcode: single-cycle result, flags, and iterative select.
    always_comb begin
        sc_out  = '0;
        sc_v    = 1'b0;
        sc_err  = 1'b0;
        op_iter = 1'b0;
        case (opCode)
            OP_ADD: begin
                sc_out = add_res;
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out = sub_res;
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   sc_out = a & b;
            OP_OR:    sc_out = a | b;
            OP_XOR:   sc_out = a ^ b;
            OP_SLL:   sc_out = a << shamt;
            OP_SRL:   sc_out = a >> shamt;
            OP_SRA:   sc_out = $unsigned($signed(a) >>> shamt);
            OP_MUL,
            OP_MULHU: op_iter = 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
            OP_DIVU,
            OP_REMU:  op_iter = 1'b1;
`endif
            default:  sc_err = 1'b1;
        endcase
    end

    // Shift-add multiply step: conditionally add the multiplicand into the high
    // half, then shift the whole {acc, mq} product register right by one.
    always_comb begin
        mul_sum = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_acc = mul_sum[WIDTH:1];
        mul_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end

`ifdef ALU_MULTICYCLE_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] div_acc;
    logic [WIDTH-1:0] div_mq;

    // Restoring divide step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always fits, which
    // naturally yields quotient all-ones and remainder equal to the dividend.
    always_comb begin
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        div_acc   = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_mq    = {mq_q[WIDTH-2:0], div_ge};
    end

    // Pick the divider or multiplier step for the op in flight.
    always_comb begin
        step_acc = op_div_q ? div_acc : mul_acc;
        step_mq  = op_div_q ? div_mq  : mul_mq;
    end
`else
    // Only the multiplier iterates in this build.
    always_comb begin
        step_acc = mul_acc;
        step_mq  = mul_mq;
    end
`endif

    // Control FSM: accept in IDLE/DONE, iterate in RUN, pulse DONE for one cycle.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        v_d      = v_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        op_hi_d  = op_hi_q;
`ifdef ALU_MULTICYCLE_DIV_EN
        op_div_d = op_div_q;
`endif
        case (state_q)
            ST_RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d   = op_hi_q ? step_acc : step_mq;
                    v_d     = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; with no request, fall back to IDLE.
                state_d = ST_IDLE;
                if (start) begin
                    op_hi_d  = opCode[0];
`ifdef ALU_MULTICYCLE_DIV_EN
                    op_div_d = opCode[1];
`endif
                    if (op_iter) begin
                        acc_d   = '0;
                        mq_d    = a;
                        opnd_d  = b;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        out_d   = sc_out;
                        v_d     = sc_v;
                        err_d   = sc_err;
                        state_d = ST_DONE;
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            op_hi_q  <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
            op_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            v_q      <= v_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            op_hi_q  <= op_hi_d;
`ifdef ALU_MULTICYCLE_DIV_EN
            op_div_q <= op_div_d;
`endif
        end
    end

    assign out       = out_q;
    assign v         = v_q;
    assign err       = err_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle: WIDTH=32 main instance plus a WIDTH=8 instance.
// Expected results are queued at issue time and compared when done pulses.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opCode = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] out;
    logic        v, err, busy, done;
    logic [1:0]  dbg_state;

    logic        start8 = 1'b0;
    logic [3:0]  op8 = 4'd0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [7:0]  out8;
    logic        v8, err8, busy8, done8;
    logic [1:0]  dbg_state8;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {out, v, err}.
    logic [33:0] exp_q[$];

    alu_multicycle #(.WIDTH(32), .SHW(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .opCode(opCode), .a(a), .b(b),
        .out(out), .v(v), .err(err), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    alu_multicycle #(.WIDTH(8), .SHW(3)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .opCode(op8), .a(a8), .b(b8),
        .out(out8), .v(v8), .err(err8), .busy(busy8), .done(done8), .dbg_state(dbg_state8)
    );

    // Clock
    always #5 clk = ~clk;

`ifdef ALU_MULTICYCLE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    function automatic bit tb_is_iter(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (DIV_EN && ((op == 4'hE) || (op == 4'hF)));
    endfunction

    // Reference model for WIDTH=32.
    function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] r;
        logic vv, ee;
        r = '0; vv = 1'b0; ee = 1'b0;
        p = {32'd0, x} * {32'd0, y};
        case (op)
            4'h0: begin r = x + y; vv = (x[31] == y[31]) && (r[31] != x[31]); end
            4'h1: begin r = x - y; vv = (x[31] != y[31]) && (r[31] != x[31]); end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = x ^ y;
            4'h8: r = x << y[4:0];
            4'h9: r = x >> y[4:0];
            4'hA: r = $unsigned($signed(x) >>> y[4:0]);
            4'hC: r = p[31:0];
            4'hD: r = p[63:32];
            4'hE: if (DIV_EN) r = (y == 0) ? 32'hFFFF_FFFF : x / y; else ee = 1'b1;
            4'hF: if (DIV_EN) r = (y == 0) ? x : x % y; else ee = 1'b1;
            default: ee = 1'b1;
        endcase
        return {r, vv, ee};
    endfunction

    // Driver: call just after a negedge. Request is taken on the next posedge;
    // afterwards the inputs are scrambled so any late sampling shows up.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [33:0] expv);
        start  = 1'b1;
        opCode = op;
        a      = x;
        b      = y;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start  = 1'b0;
        opCode = 4'($urandom_range(0, 15));
        a      = $urandom;
        b      = $urandom;
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got out=%h v=%b err=%b, required no done pulse", out, v, err);
            end else begin
                e = exp_q.pop_front();
                if ({out, v, err} !== e) begin
                    errors++;
                    $display("FAIL result: got out=%h v=%b err=%b, required out=%h v=%b err=%b",
                             out, v, err, e[33:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out, v, err, busy, done} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h v=%b err=%b busy=%b done=%b, required all 0", out, v, err, busy, done);
        end
        checks++;
        if ({out8, v8, err8, busy8, done8} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs8: got out=%h v=%b err=%b busy=%b done=%b, required all 0", out8, v8, err8, busy8, done8);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Issue one op and check done latency and busy cycle count inline.
    task automatic test_single_cycle();
        logic [3:0]  ops [12] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'h2, 4'h3, 4'h7, 4'hB};
        logic [31:0] x, y;
        int n;
        // Directed vectors with fixed expectations.
        issue(4'h0, 32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 1'b1, 1'b0});
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_latency: got done=%b busy=%b at k+1, required done=1 busy=0", done, busy);
        end
        issue(4'hA, 32'h8000_0000, 32'h24, {32'hF800_0000, 1'b0, 1'b0});
        @(negedge clk);
        issue(4'h8, 32'h8000_0000, 32'h24, {32'h0000_0000, 1'b0, 1'b0});
        @(negedge clk);
        issue(4'h1, 32'h8000_0000, 32'h1, {32'h7FFF_FFFF, 1'b1, 1'b0});
        @(negedge clk);
        issue(4'h7, 32'h1234_5678, 32'h9ABC_DEF0, {32'h0, 1'b0, 1'b1});
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL illegal_latency: got done=%b at k+1, required 1", done);
        end
        // Randomized operands over every single-cycle and illegal opcode.
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom)} : $urandom;
            if (i % 4 == 0) @(negedge clk);
            issue(ops[i % 12], x, y, model(ops[i % 12], x, y));
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done !== 1'b1 && n < 40);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL single_latency op=%h: got %0d cycles, required 1", ops[i % 12], n);
            end
        end
    endtask

    task automatic test_iterative();
        logic [3:0]  op;
        logic [31:0] x, y;
        int n, nb, lat;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin op = 4'hD; x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
                1: begin op = 4'hC; x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
                2: begin op = 4'hE; x = 32'd100; y = 32'd7; end
                3: begin op = 4'hF; x = 32'd100; y = 32'd7; end
                4: begin op = 4'hE; x = 32'hDEAD_BEEF; y = 32'd0; end
                5: begin op = 4'hF; x = 32'hDEAD_BEEF; y = 32'd0; end
                default: begin
                    op = 4'($urandom_range(12, 15));
                    x  = $urandom;
                    y  = (i == 9) ? 32'($urandom_range(1, 255)) : $urandom;
                end
            endcase
            issue(op, x, y, model(op, x, y));
            lat = tb_is_iter(op) ? 33 : 1;
            n = 0;
            nb = 0;
            do begin
                @(negedge clk);
                n++;
                if (busy === 1'b1) nb++;
            end while (done !== 1'b1 && n < 60);
            checks++;
            if (n != lat || nb != lat - 1) begin
                errors++;
                $display("FAIL iter_latency op=%h: got done after %0d cycles busy %0d, required %0d and %0d",
                         op, n, nb, lat, lat - 1);
            end
        end
        // Fixed-value spot checks independent of the model.
        checks++;
        if (model(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF) !== {32'hFFFF_FFFE, 2'b00} ||
            model(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF) !== {32'h0000_0001, 2'b00}) begin
            errors++;
            $display("FAIL model_mul_vectors: reference model disagrees with known products");
        end
    endtask

    // start held high for the whole multiply: only one op may execute.
    task automatic test_start_held();
        int nb;
        issue(4'hC, 32'h0001_0003, 32'h0000_0005, {32'h0005_000F, 2'b00});
        start  = 1'b1;
        opCode = 4'h0;
        nb = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (i == 32) start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (nb != 32 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_held: got busy %0d cycles done=%b, required 32 and 1", nb, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_held_extra: got done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    // New request issued in the DONE cycle of the previous one, no bubble.
    task automatic test_back_to_back();
        int n;
        issue(4'hC, 32'd12345, 32'd678, model(4'hC, 32'd12345, 32'd678));
        repeat (33) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got done=%b, required 1", done);
        end
        issue(4'h0, 32'hFFFF_FFFF, 32'h2, {32'h1, 2'b00});
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: got done=%b, required 1", done);
        end
        issue(4'hD, 32'h8000_0000, 32'h4, {32'h2, 2'b00});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL b2b_third_latency: got %0d cycles, required 33", n);
        end
    endtask

    // Reset in the middle of a multiply aborts it with no done pulse.
    task automatic test_reset_mid_run();
        int nd;
        issue(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 2'b00});
        repeat (9) @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        opCode = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({out, v, err, busy, done} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got out=%h v=%b err=%b busy=%b done=%b, required all 0", out, v, err, busy, done);
        end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d active cycles after reset, required 0", nd);
        end
    endtask

    // Narrow instance: carry without overflow, and overflow without carry.
    task automatic test_width8();
        logic [7:0] xs [3] = '{8'hFF, 8'h7F, 8'h80};
        logic [7:0] ys [3] = '{8'h01, 8'h01, 8'h80};
        logic [9:0] ex [3] = '{{8'h00, 2'b00}, {8'h80, 2'b10}, {8'h00, 2'b10}};
        for (int i = 0; i < 3; i++) begin
            start8 = 1'b1;
            op8    = 4'h0;
            a8     = xs[i];
            b8     = ys[i];
            @(posedge clk);
            #1;
            start8 = 1'b0;
            a8     = 8'($urandom);
            @(negedge clk);
            checks++;
            if (done8 !== 1'b1 || {out8, v8, err8} !== ex[i]) begin
                errors++;
                $display("FAIL width8_add %h+%h: got done=%b out=%h v=%b err=%b, required done=1 out=%h v=%b err=%b",
                         xs[i], ys[i], done8, out8, v8, err8, ex[i][9:2], ex[i][1], ex[i][0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_iterative();
        test_start_held();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW = log2(WIDTH), default 5, shift-amount width.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted on a rising edge when busy=0.
REQ-006 opCode  input  4  operation select, sampled on acceptance.
REQ-007 a  input  WIDTH  operand A, sampled on acceptance.
REQ-008 b  input  WIDTH  operand B, sampled on acceptance.
REQ-009 out  output  WIDTH  registered result, held until next done.
REQ-010 v  output  1  signed overflow, ADD/SUB only, else 0; registered with out.
REQ-011 err  output  1  illegal opcode flag; registered with out.
REQ-012 busy  output  1  high while an iterative op runs.
REQ-013 done  output  1  one-cycle pulse; out/v/err valid from this cycle on.

Function
REQ-014 Opcodes SHALL be: ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, SLL 1000, SRL 1001, SRA 1010, MUL 1100, MULHU 1101, DIVU 1110, REMU 1111.
REQ-015 Opcodes 0010, 0011, 0111, 1011 SHALL be illegal: out=0, v=0, err=1, single-cycle latency.
REQ-016 ADD/SUB SHALL be modulo 2^WIDTH; v=1 when operand signs agree (ADD) or differ (SUB) and result sign differs from a.
REQ-017 Shifts SHALL use b[SHW-1:0] only; SRA replicates a[WIDTH-1].
REQ-018 MUL SHALL return low WIDTH bits, MULHU the high WIDTH bits, of unsigned a*b.
REQ-019 DIVU/REMU SHALL return unsigned quotient/remainder; b=0 gives quotient all-ones, remainder = a, err=0.
REQ-020 FSM states IDLE, RUN, DONE; IDLE->DONE on accepted single-cycle op; IDLE->RUN on accepted MUL/MULHU/DIVU/REMU; RUN->DONE after WIDTH iteration cycles; DONE->IDLE, or DONE->RUN/DONE when start is accepted in DONE.
REQ-021 Single-cycle ops: accept at edge k, done=1 in cycle k+1.
REQ-022 Iterative ops: one shift-add / restoring-subtract step per cycle; accept at edge k, busy=1 cycles k+1..k+WIDTH, done=1 in cycle k+WIDTH+1.
REQ-023 busy SHALL be 1 exactly in RUN; start while busy=1 SHALL be ignored, no side effects.
REQ-024 start in a DONE cycle SHALL be accepted (back-to-back issue, no bubble).
REQ-025 Input changes after acceptance SHALL NOT affect the in-flight result.
REQ-026 out/v/err SHALL change only on the edge that raises done.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE; out=0, v=0, err=0, busy=0, done=0 next cycle.
REQ-028 reset mid-RUN SHALL abort the op with no done pulse; reset has priority over start.

Configuration
REQ-029 Macro ALU_MULTICYCLE_DIV_EN: defined -> DIVU/REMU as REQ-019, REQ-022.
REQ-030 Undefined -> no divider logic; DIVU/REMU treated as illegal per REQ-015 (err=1, out=0, done at k+1).

Verification
REQ-031 WIDTH=32: ADD a=0x7FFFFFFF b=1 -> done at k+1, out=0x80000000, v=1, err=0.
REQ-032 WIDTH=32: SRA a=0x80000000 b=0x24 -> out=0xF8000000 (shift 4); SLL same operands -> 0x00000000.
REQ-033 WIDTH=32: MULHU a=b=0xFFFFFFFF -> busy 32 cycles, done at k+33, out=0xFFFFFFFE; MUL -> 0x00000001.
REQ-034 DIV_EN defined: DIVU a=100 b=7 -> out=14; REMU -> 2; DIVU b=0 -> 0xFFFFFFFF, err=0; undefined: DIVU -> out=0, err=1 at k+1.
REQ-035 start held high through MUL -> only one op executes; new start in DONE cycle -> accepted, next done correct.
REQ-036 reset at cycle k+10 of MUL -> no done pulse, all outputs 0; opcode 0111 -> err=1, out=0; WIDTH=8 ADD 0xFF+0x01 -> 0x00, v=0.
